dbuf_seq_ctrl: RTL and testbench
================================

DBUF_SEQ_CTRL -- requirements
Module: dbuf_seq_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 4, number of buffer stages sequenced (2..16).
REQ-002 SHALL have parameter DLY_W, default 8, width of the inter-stage delay configuration.
REQ-003 SHALL have parameter TO_CYC, default 1024, power-good timeout in clock cycles.
REQ-004 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-006 SHALL have ports CELV, CELG and SUB  input  1 each  supply, ground and substrate pins; no logical function.
REQ-007 SHALL have port en_req  input  1  level request to enable the buffer bank.
REQ-008 SHALL have port dly_cfg  input  DLY_W  inter-stage delay in cycles.
REQ-009 SHALL have port pgood  input  1  downstream supply good.
REQ-010 SHALL have port fault  input  1  external fault, level.
REQ-011 SHALL have port en_stage  output  NSTAGE  per-stage buffer enables.
REQ-012 SHALL have port en_ack  output  1  bank fully on and pgood seen.
REQ-013 SHALL have ports busy and fault_flg  output  1 each.

Function
REQ-014 SHALL implement states IDLE, RAMP_UP, ON, RAMP_DN and FAULT; busy = (state != IDLE).
REQ-015 SHALL, in IDLE with en_req=1, enter RAMP_UP and set en_stage[0] on the same edge.
REQ-016 SHALL space successive stage enables exactly D = max(dly_cfg,1) cycles apart; dly_cfg is sampled at each interval reload.
REQ-017 SHALL, D cycles after the last stage enable, enter ON and set en_ack if pgood=1; otherwise hold in RAMP_UP until pgood=1, then enter ON on the next edge.
REQ-018 SHALL, on en_req=0 in RAMP_UP or ON, enter RAMP_DN, clear en_ack on the same edge, and keep every stage enabled at that moment.
REQ-019 SHALL, in RAMP_DN, clear the highest set stage bit every D cycles with the first clear D cycles after entry, and enter IDLE on the edge that clears bit 0.
REQ-020 SHALL ignore en_req=1 during RAMP_DN; the request is evaluated again in IDLE.
REQ-021 SHALL, on fault=1 in any state, enter FAULT on the next edge, clear en_stage and en_ack on that edge, and set fault_flg.
REQ-022 SHALL leave FAULT to IDLE only when fault=0 and en_req=0; fault_flg clears on that edge.
REQ-023 SHALL give fault priority over en_req when both change in the same cycle.
REQ-024 SHALL keep en_stage thermometer-coded (bit k set implies bits 0..k-1 set) at all times.

Reset
REQ-025 SHALL, with RST=1 at an edge, enter IDLE and set en_stage=0, en_ack=0, busy=0, fault_flg=0, and clear the counters.
REQ-026 SHALL, on reset mid-ramp, drop all enables on that edge with no ramp-down.

Configuration
REQ-027 SHALL, with DBUF_SEQ_TIMEOUT_EN defined, count cycles spent waiting for pgood in RAMP_UP and enter FAULT with fault_flg=1 when the count reaches TO_CYC.
REQ-028 SHALL, without DBUF_SEQ_TIMEOUT_EN, wait for pgood indefinitely and contain no timeout counter.

Structure
REQ-029 SHALL take the state enumeration and the default constants for NSTAGE, DLY_W and TO_CYC from shared package dbuf_seq_pkg.
REQ-030 SHALL place the reloadable interval down-counter in sub-module dbuf_seq_tmr; the FSM stays in dbuf_seq_ctrl.

Verification
REQ-031 SHALL cover ramp-up: NSTAGE=4, dly_cfg=3, pgood=1, en_req rises at edge 0 -> en_stage = 0001@1, 0011@4, 0111@7, 1111@10; en_ack@13.
REQ-032 SHALL cover ramp-down: from ON, en_req=0 at edge 0 -> en_ack=0@0; en_stage = 0111@3, 0011@6, 0001@9, 0000@12; busy=0@12.
REQ-033 SHALL cover abort: fault=1 during RAMP_UP with en_stage=0011 -> en_stage=0000 and fault_flg=1 the next edge; IDLE only after fault=0 and en_req=0.
REQ-034 SHALL cover zero delay: dly_cfg=0 -> stages enable on consecutive edges, identical to dly_cfg=1.
REQ-035 SHALL cover the timeout: DBUF_SEQ_TIMEOUT_EN defined, TO_CYC=16, pgood held 0 -> FAULT 16 cycles after the final interval expires; without the macro, the block stays in RAMP_UP.
REQ-036 SHALL cover reset: RST=1 asserted mid-RAMP_DN -> all outputs 0 at that edge, and the block is in IDLE.

Source files
------------

// File: rtl/dbuf_seq_pkg.sv
// Shared types and default constants for the buffer-bank sequencer.
// Used by dbuf_seq_ctrl and dbuf_seq_tmr.
package dbuf_seq_pkg;

    localparam int NSTAGE_DEF = 4;
    localparam int DLY_W_DEF  = 8;
    localparam int TO_CYC_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DN,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/dbuf_seq_tmr.sv
// Reloadable interval down-counter: after a load, expired rises exactly
// max(dly,1) edges later and stays high until the next load.
module dbuf_seq_tmr #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] dly,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Loading D-1 makes the zero-count edge land D cycles after the load edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (dly == '0) ? '0 : dly - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/dbuf_seq_ctrl.sv
// Staged enable sequencer for a buffer bank with power-good handshake.
// Optional pgood timeout is compiled in with `define DBUF_SEQ_TIMEOUT_EN.
module dbuf_seq_ctrl
    import dbuf_seq_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int DLY_W  = DLY_W_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic              en_req,
    input  logic [DLY_W-1:0]  dly_cfg,
    input  logic              pgood,
    input  logic              fault,
    output logic [NSTAGE-1:0] en_stage,
    output logic              en_ack,
    output logic              busy,
    output logic              fault_flg
);

    state_t            state;
    state_t            state_nxt;
    logic [NSTAGE-1:0] stage_nxt;
    logic              tmr_load;
    logic              tmr_exp;
    logic              all_on;
    logic              only_first;
    logic              timeout;
    logic              unused_pins;

    assign unused_pins = ^{CELV, CELG, SUB};
    assign all_on      = en_stage[NSTAGE-1];
    assign only_first  = (en_stage == NSTAGE'(1));

    dbuf_seq_tmr #(.W(DLY_W)) u_tmr (
        .CLK     (CLK),
        .RST     (RST),
        .load    (tmr_load),
        .dly     (dly_cfg),
        .expired (tmr_exp)
    );

`ifdef DBUF_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            pg_wait;

    // Counts edges spent fully ramped with the final interval expired but no pgood.
    assign pg_wait = (state == ST_RAMP_UP) && all_on && tmr_exp && !pgood;
    assign timeout = pg_wait && (to_cnt >= TO_W'(TO_CYC));

    always_ff @(posedge CLK) begin
        if (RST || !pg_wait) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            en_stage <= '0;
        end else begin
            state    <= state_nxt;
            en_stage <= stage_nxt;
        end
    end

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch.
        state_nxt = state;
        if (fault) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE:    if (en_req) state_nxt = ST_RAMP_UP;
                ST_RAMP_UP: begin
                    if (!en_req) begin
                        state_nxt = ST_RAMP_DN;
                    end else if (tmr_exp && all_on) begin
                        if (pgood)        state_nxt = ST_ON;
                        else if (timeout) state_nxt = ST_FAULT;
                    end
                end
                ST_ON:      if (!en_req) state_nxt = ST_RAMP_DN;
                ST_RAMP_DN: if (tmr_exp && only_first) state_nxt = ST_IDLE;
                ST_FAULT:   if (!en_req) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Stage shifts keep en_stage thermometer-coded; every shift reloads the interval.
    always_comb begin
        busy      = (state != ST_IDLE);
        en_ack    = (state == ST_ON);
        fault_flg = (state == ST_FAULT);
        stage_nxt = en_stage;
        tmr_load  = 1'b0;
        case (state_nxt)
            ST_IDLE, ST_FAULT: stage_nxt = '0;
            ST_RAMP_UP: begin
                if (state == ST_IDLE) begin
                    stage_nxt = NSTAGE'(1);
                    tmr_load  = 1'b1;
                end else if (tmr_exp && !all_on) begin
                    stage_nxt = {en_stage[NSTAGE-2:0], 1'b1};
                    tmr_load  = 1'b1;
                end
            end
            ST_RAMP_DN: begin
                if (state != ST_RAMP_DN) begin
                    tmr_load = 1'b1;
                end else if (tmr_exp) begin
                    stage_nxt = {1'b0, en_stage[NSTAGE-1:1]};
                    tmr_load  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dbuf_seq_ctrl.sv
// Scoreboard bench for dbuf_seq_ctrl: a cycle-level behavioural model pushes
// expected outputs per edge; a monitor pops and compares on the falling edge.
module tb_dbuf_seq_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;
`ifdef DBUF_SEQ_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST, CELV, CELG, SUB, en_req, pgood, fault;
    logic [DW-1:0] dly_cfg;
    logic [N-1:0]  en_stage;
    logic          en_ack, busy, fault_flg;

    dbuf_seq_ctrl #(.NSTAGE(N), .DLY_W(DW), .TO_CYC(TO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CELV      (CELV),
        .CELG      (CELG),
        .SUB       (SUB),
        .en_req    (en_req),
        .dly_cfg   (dly_cfg),
        .pgood     (pgood),
        .fault     (fault),
        .en_stage  (en_stage),
        .en_ack    (en_ack),
        .busy      (busy),
        .fault_flg (fault_flg)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0] stage;
        logic         ack;
        logic         bsy;
        logic         flt;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   sb_on = 1'b1;

    // Model: mode 0 idle, 1 ramping up, 2 on, 3 ramping down, 4 fault;
    // k = number of stages on, t = cycles since last stage event, d = interval.
    int m_mode = 0, m_k = 0, m_t = 0, m_d = 1;

    function automatic int dmax(input logic [DW-1:0] c);
        return (c == '0) ? 1 : int'(c);
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            m_mode = 0; m_k = 0;
        end else if (fault) begin
            m_mode = 4; m_k = 0;
        end else begin
            case (m_mode)
                0: if (en_req) begin m_mode = 1; m_k = 1; m_d = dmax(dly_cfg); m_t = 0; end
                1: begin
                    m_t++;
                    if (!en_req) begin
                        m_mode = 3; m_d = dmax(dly_cfg); m_t = 0;
                    end else if (m_t >= m_d) begin
                        if (m_k < N) begin
                            m_k++; m_d = dmax(dly_cfg); m_t = 0;
                        end else if (pgood) begin
                            m_mode = 2;
                        end else if (TO_ON && (m_t - m_d >= TO)) begin
                            m_mode = 4; m_k = 0;
                        end
                    end
                end
                2: if (!en_req) begin m_mode = 3; m_d = dmax(dly_cfg); m_t = 0; end
                3: begin
                    m_t++;
                    if (m_t >= m_d) begin
                        m_k--;
                        if (m_k == 0) m_mode = 0;
                        else begin m_d = dmax(dly_cfg); m_t = 0; end
                    end
                end
                default: if (!en_req) m_mode = 0;
            endcase
        end
        if (sb_on)
            exp_q.push_back('{stage: N'((1 << m_k) - 1), ack: (m_mode == 2),
                              bsy: (m_mode != 0), flt: (m_mode == 4)});
    end

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got stage=%b ack=%b busy=%b flt=%b, expected stage=%b ack=%b busy=%b flt=%b",
                     name, cyc, got.stage, got.ack, got.bsy, got.flt,
                     want.stage, want.ack, want.bsy, want.flt);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            check("outputs", '{stage: en_stage, ack: en_ack, bsy: busy, flt: fault_flg}, e);
        end
    end

    task automatic drive(input bit r, input bit e, input bit f, input bit p,
                         input int cfg, input int n);
        RST = r; en_req = e; fault = f; pgood = p; dly_cfg = DW'(cfg);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
        drive(1, 0, 0, 1, 0, 2);               // reset state
        drive(0, 1, 0, 1, 3, 20);              // ramp-up D=3 to ON
        drive(0, 0, 0, 1, 3, 15);              // ramp-down to IDLE
        drive(0, 1, 0, 1, 2, 3);               // partial ramp (0011)
        drive(0, 1, 1, 1, 2, 3);               // fault abort
        drive(0, 1, 0, 1, 2, 3);               // held in FAULT by en_req
        drive(0, 0, 0, 1, 2, 2);               // release to IDLE
        drive(0, 1, 0, 1, 0, 8);               // zero delay ramp
        drive(0, 0, 0, 1, 0, 8);
        drive(0, 1, 0, 1, 1, 8);               // D=1 ramp for comparison
        drive(0, 0, 0, 1, 1, 8);
        drive(0, 1, 0, 1, 2, 14);              // up, then request ignored while ramping down
        drive(0, 0, 0, 1, 2, 2);
        drive(0, 1, 0, 1, 2, 24);
        drive(0, 0, 0, 1, 2, 10);
        drive(0, 1, 0, 0, 1, 40);              // pgood held low: wait or timeout
        drive(0, 1, 0, 1, 1, 3);
        drive(0, 0, 0, 1, 4, 10);              // mid ramp-down, then reset
        drive(1, 0, 0, 1, 4, 1);
        drive(0, 0, 0, 1, 4, 3);
        for (int i = 0; i < 300; i++) begin
            bit r, e, f, p;
            int n;
            r = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 11) == 0);
            e = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 3) != 0);
            n = r ? 1 : int'($urandom_range(1, 20));
            drive(r, e, f, p, int'($urandom_range(0, 3)), n);
        end
        sb_on = 1'b0;
        @(negedge CLK);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
